// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//
// Contents:
//   DIV_MIN    - smallest divisor the counter can run with
//   clamp_div  - maps requested divisors 0 and 1 onto DIV_MIN
//   high_len   - length of the high phase for divisor n, floor(n/2)
//
// The helpers work on 32-bit values; callers cast to their own WIDTH.
// This limits WIDTH to 32 bits or fewer.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  // Divisors below DIV_MIN would give a zero-length phase, so treat them as DIV_MIN.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < 32'(DIV_MIN)) ? 32'(DIV_MIN) : value;
  endfunction

  function automatic logic [31:0] high_len(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/div_config_reg.sv
// Divisor configuration register for programmable_clock_divider.
//
// Holds the active divisor and one pending request. A request is
// captured on div_load and made active on the next apply edge: a
// period wrap, or any edge while the divider is disabled. A load that
// coincides with an apply edge skips the pending stage and becomes
// active on that edge. Each activation gives one div_ack pulse in the
// following cycle.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   div_value  in   requested divisor (0/1 treated as 2)
//   div_load   in   single-cycle capture strobe
//   apply      in   current edge is a period boundary
//   active_div out  divisor currently in force
//   div_ack    out  one-cycle pulse after a divisor becomes active
module div_config_reg
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  input  logic             apply,
  output logic [WIDTH-1:0] active_div,
  output logic             div_ack
);

  logic [WIDTH-1:0] req_div;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pending_div_q, pending_div_d;
  logic             pending_q, pending_d;
  logic             ack_q, ack_d;

  assign req_div = WIDTH'(clamp_div(32'(div_value)));

  always_comb begin
    active_d      = active_q;
    pending_div_d = pending_div_q;
    pending_d     = pending_q;
    ack_d         = 1'b0;
    if (apply) begin
      if (div_load) begin
        // Incoming request wins over anything still pending.
        active_d  = req_div;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end else if (pending_q) begin
        active_d  = pending_div_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
    end else if (div_load) begin
      // Repeated loads overwrite; only the final value is acknowledged.
      pending_div_d = req_div;
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q      <= WIDTH'(DEFAULT_DIV);
      pending_div_q <= WIDTH'(DEFAULT_DIV);
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      active_q      <= active_d;
      pending_div_q <= pending_div_d;
      pending_q     <= pending_d;
      ack_q         <= ack_d;
    end
  end

  assign active_div = active_q;
  assign div_ack    = ack_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Programmable integer clock divider.
//
// Divides clock by N (runtime programmable). Each period is a low
// phase of N-floor(N/2) cycles followed by a high phase of floor(N/2)
// cycles; tick pulses in the last cycle of every period. Divisor
// changes only take effect on a period boundary so clk_div_out never
// glitches.
//
// Configuration macro: DUTY50_ODD_EN
//   When defined, a falling-edge flop stretches the high phase by half
//   a clock for odd N, giving an exact 50% duty cycle. When undefined
//   the design is rise-edge only.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   enable      in   run when high; hold in idle low phase when low
//   div_value   in   requested divisor N (0/1 treated as 2)
//   div_load    in   single-cycle request to capture div_value
//   div_ack     out  one-cycle pulse when the new divisor is active
//   clk_div_out out  divided clock
//   tick        out  one-cycle pulse in the last cycle of each period
module programmable_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_div_out,
  output logic             tick
);

  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] hi_len;
  logic [WIDTH-1:0] low_len;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             apply;

  div_config_reg #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div_config_reg (
    .clock      (clock),
    .reset      (reset),
    .div_value  (div_value),
    .div_load   (div_load),
    .apply      (apply),
    .active_div (active_div),
    .div_ack    (div_ack)
  );

  // N >= 2 always, so neither subtraction can underflow.
  assign hi_len   = WIDTH'(high_len(32'(active_div)));
  assign low_len  = active_div - hi_len;
  assign last_cnt = active_div - WIDTH'(1);

  assign wrap  = enable && (cnt_q >= last_cnt);
  // Disabled edges are also boundaries: the counter sits at 0.
  assign apply = wrap || !enable;

  // The divisor only changes on edges where cnt_d is 0. At cnt_d == 0
  // the phase is low and tick is clear for any N >= 2, so decoding
  // against the current divisor is safe.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    tick_d  = 1'b0;
    if (enable && !wrap) begin
      cnt_d   = cnt_q + WIDTH'(1);
      phase_d = (cnt_d >= low_len);
      tick_d  = (cnt_d == last_cnt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef DUTY50_ODD_EN
  logic phase_fall_q;

  // Half-cycle delayed copy of the phase; OR-ing it in for odd N moves
  // the falling edge of clk_div_out half a clock later.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      phase_fall_q <= 1'b0;
    end else begin
      phase_fall_q <= phase_q;
    end
  end

  assign clk_div_out = phase_q | (active_div[0] & phase_fall_q);
`else
  assign clk_div_out = phase_q;
`endif

endmodule
